soc_pwr_timer: RTL
==================

SOC_PWR_TIMER -- requirements
Module: soc_pwr_timer

Interface
REQ-001 SHALL have parameter p_prescale, default 10, i_clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have parameter p_wake_delay, default 4, cycles o_sleep stays high after a wake event (legal range 1..255).
REQ-003 SHALL have parameter p_num_gpios, default 24, width of the GPIO wake input.
REQ-004 SHALL have port i_clk  in  1  global clock, rising edge.
REQ-005 SHALL have port i_rst  in  1  global reset, asynchronous, active-high.
REQ-006 SHALL have port i_bus_valid  in  1  register access request.
REQ-007 SHALL have port i_bus_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have port i_bus_addr  in  5  byte offset, word aligned.
REQ-009 SHALL have port i_bus_wdata  in  32  write data.
REQ-010 SHALL have port o_bus_ready  out  1  one-cycle access-complete pulse.
REQ-011 SHALL have port o_bus_rdata  out  32  read data, valid while o_bus_ready is high.
REQ-012 SHALL have port i_gpio_in  in  p_num_gpios  GPIO pin levels for wake.
REQ-013 SHALL have port o_mtime  out  64  system time to the SoC i_mtime input.
REQ-014 SHALL have port o_sleep  out  1  active-high sleep control to the SoC i_sleep input.
REQ-015 SHALL have port o_timer_irq  out  1  machine timer interrupt, level.

Function
REQ-016 SHALL map registers: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL, 0x14 WAKE_MASK; other offsets read 0, writes ignored.
REQ-017 SHALL assert o_bus_ready exactly one cycle after a cycle with i_bus_valid high and o_bus_ready low; back-to-back accesses complete every second cycle.
REQ-018 SHALL increment mtime by 1 when the prescaler (counting 0..p_prescale-1) wraps; p_prescale=1 increments every cycle; mtime wraps from 2^64-1 to 0.
REQ-019 SHALL, on a MTIME_LO/HI write in the same cycle as an increment, load the written word, keep the other word, and drop the increment.
REQ-020 SHALL register o_timer_irq = (mtime >= mtimecmp), unsigned 64-bit, one cycle latency.
REQ-021 SHALL define CTRL bit0 SLEEP (write 1 requests sleep, reads current o_sleep), bit1 TIMER_WAKE_EN, bit2 GPIO_WAKE_EN; other bits read 0.
REQ-022 SHALL implement FSM RUN -> SLEEP on the cycle after a CTRL write with bit0=1; SLEEP -> WAKE on a wake event; WAKE -> RUN after p_wake_delay cycles.
REQ-023 SHALL drive o_sleep high in SLEEP and WAKE, low in RUN.
REQ-024 SHALL define wake event = (TIMER_WAKE_EN and o_timer_irq) or (GPIO_WAKE_EN and |(i_gpio_in & WAKE_MASK)); a wake event already true at sleep entry leaves SLEEP on the next cycle.
REQ-025 SHALL keep mtime counting and the bus serviced in every state; CTRL SLEEP writes outside RUN are ignored.

Reset
REQ-026 SHALL, on i_rst, asynchronously set: mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, WAKE_MASK=0, FSM=RUN, o_sleep=0, o_timer_irq=0, o_bus_ready=0, o_bus_rdata=0.
REQ-027 SHALL abort any SLEEP/WAKE sequence on reset mid-operation and resume in RUN on release.

Configuration
REQ-028 SHALL, with SOC_PWR_GPIO_WAKE_EN defined, implement WAKE_MASK, CTRL bit2 and the GPIO wake term.
REQ-029 SHALL, without SOC_PWR_GPIO_WAKE_EN, read WAKE_MASK and CTRL bit2 as 0, ignore i_gpio_in, and wake only on the timer.

Structure
REQ-030 SHALL place the FSM state enum, register offset constants and CTRL bit indices in package soc_pwr_pkg.
REQ-031 SHALL implement the prescaler plus 64-bit counter as sub-module soc_pwr_mtime.

Verification
REQ-032 SHALL check p_prescale=10: after reset release, o_mtime=0, then 1 after 10 cycles, then 5 after 50 cycles.
REQ-033 SHALL check: write MTIMECMP_HI=0, MTIMECMP_LO=20 -> o_timer_irq rises exactly one cycle after mtime reaches 20.
REQ-034 SHALL check: TIMER_WAKE_EN=1, mtimecmp=mtime+3, CTRL SLEEP write -> o_sleep high until 4 cycles after the irq, then RUN.
REQ-035 SHALL check with the macro: WAKE_MASK=0x000001, GPIO_WAKE_EN=1, sleep, pulse i_gpio_in[0] -> wake; pulse i_gpio_in[1] -> no wake.
REQ-036 SHALL check: MTIME_LO write of 0xFFFF_FFFF with HI=0xFFFF_FFFF -> next increment gives o_mtime=0.
REQ-037 SHALL check: i_rst asserted while in SLEEP -> o_sleep=0 immediately, no clock edge required.

Source files
------------

// File: rtl/soc_pwr_pkg.sv
// Shared types and constants for the SoC power/timer block: FSM states,
// register offsets and CTRL bit positions.
package soc_pwr_pkg;

  localparam int unsigned PRE_W  = 16;
  localparam int unsigned WCNT_W = 8;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } pwr_state_e;

  localparam logic [ADDR_W-1:0] ADDR_MTIME_LO    = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_MTIME_HI    = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_LO = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_HI = 5'h0C;
  localparam logic [ADDR_W-1:0] ADDR_CTRL        = 5'h10;
  localparam logic [ADDR_W-1:0] ADDR_WAKE_MASK   = 5'h14;

  localparam int unsigned CTRL_SLEEP      = 0;
  localparam int unsigned CTRL_TIMER_WAKE = 1;
  localparam int unsigned CTRL_GPIO_WAKE  = 2;

endpackage

// File: rtl/soc_pwr_mtime.sv
// Prescaler plus 64-bit machine timer; a word load wins over a same-cycle increment.
module soc_pwr_mtime
  import soc_pwr_pkg::*;
#(
  parameter int unsigned p_prescale = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ld_lo,
  input  logic        i_ld_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_mtime
);

  logic [PRE_W-1:0] pre_q;
  logic             tick;

  assign tick = (pre_q == PRE_W'(p_prescale - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_q   <= '0;
      o_mtime <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (i_ld_lo)      o_mtime[31:0]  <= i_wdata;
      else if (i_ld_hi) o_mtime[63:32] <= i_wdata;
      else if (tick)    o_mtime        <= o_mtime + 64'd1;
    end
  end

endmodule

// File: rtl/soc_pwr_timer.sv
// SoC machine timer with sleep/wake sequencer and a simple register bus.
// Define SOC_PWR_GPIO_WAKE_EN to add WAKE_MASK and GPIO-triggered wake.
module soc_pwr_timer
  import soc_pwr_pkg::*;
#(
  parameter int unsigned p_prescale   = 10,
  parameter int unsigned p_wake_delay = 4,
  parameter int unsigned p_num_gpios  = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_bus_valid,
  input  logic                   i_bus_we,
  input  logic [4:0]             i_bus_addr,
  input  logic [31:0]            i_bus_wdata,
  output logic                   o_bus_ready,
  output logic [31:0]            o_bus_rdata,
  input  logic [p_num_gpios-1:0] i_gpio_in,
  output logic [63:0]            o_mtime,
  output logic                   o_sleep,
  output logic                   o_timer_irq
);

  logic        acc, wr;
  logic [63:0] mtimecmp;
  logic        timer_wake_en;
  logic        gpio_wake, gpio_en_rd;
  logic [31:0] mask_rd, rd_mux;
  logic        sleep_req, wake;
  pwr_state_e  state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  // An access is taken only when no completion pulse is pending
  assign acc = i_bus_valid & ~o_bus_ready;
  assign wr  = acc & i_bus_we;

  soc_pwr_mtime #(.p_prescale(p_prescale)) u_mtime (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ld_lo (wr && (i_bus_addr == ADDR_MTIME_LO)),
    .i_ld_hi (wr && (i_bus_addr == ADDR_MTIME_HI)),
    .i_wdata (i_bus_wdata),
    .o_mtime (o_mtime)
  );

`ifdef SOC_PWR_GPIO_WAKE_EN
  logic [p_num_gpios-1:0] wake_mask;
  logic                   gpio_wake_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wake_mask    <= '0;
      gpio_wake_en <= 1'b0;
    end else if (wr) begin
      if (i_bus_addr == ADDR_WAKE_MASK) wake_mask <= i_bus_wdata[p_num_gpios-1:0];
      if (i_bus_addr == ADDR_CTRL)      gpio_wake_en <= i_bus_wdata[CTRL_GPIO_WAKE];
    end
  end

  assign gpio_wake  = gpio_wake_en & (|(i_gpio_in & wake_mask));
  assign gpio_en_rd = gpio_wake_en;
  assign mask_rd    = 32'(wake_mask);
`else
  logic unused_gpio;
  assign unused_gpio = ^i_gpio_in;
  assign gpio_wake   = 1'b0;
  assign gpio_en_rd  = 1'b0;
  assign mask_rd     = '0;
`endif

  assign wake      = (timer_wake_en & o_timer_irq) | gpio_wake;
  assign sleep_req = wr && (i_bus_addr == ADDR_CTRL) && i_bus_wdata[CTRL_SLEEP];

  always_comb begin
    rd_mux = '0;
    case (i_bus_addr)
      ADDR_MTIME_LO:    rd_mux = o_mtime[31:0];
      ADDR_MTIME_HI:    rd_mux = o_mtime[63:32];
      ADDR_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      ADDR_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      ADDR_CTRL:        rd_mux = {29'd0, gpio_en_rd, timer_wake_en, o_sleep};
      ADDR_WAKE_MASK:   rd_mux = mask_rd;
      default:          rd_mux = '0;
    endcase
  end

  // Bus response, compare register, timer enable and interrupt
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_ready   <= 1'b0;
      o_bus_rdata   <= '0;
      mtimecmp      <= '1;
      timer_wake_en <= 1'b0;
      o_timer_irq   <= 1'b0;
    end else begin
      o_bus_ready <= acc;
      o_bus_rdata <= (acc && !i_bus_we) ? rd_mux : '0;
      o_timer_irq <= (o_mtime >= mtimecmp);
      if (wr) begin
        if (i_bus_addr == ADDR_MTIMECMP_LO) mtimecmp[31:0]  <= i_bus_wdata;
        if (i_bus_addr == ADDR_MTIMECMP_HI) mtimecmp[63:32] <= i_bus_wdata;
        if (i_bus_addr == ADDR_CTRL)        timer_wake_en   <= i_bus_wdata[CTRL_TIMER_WAKE];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (sleep_req) state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (wake) begin
          state_d = ST_WAKE;
          wcnt_d  = '0;
        end
      end
      ST_WAKE: begin
        if (wcnt_q == WCNT_W'(p_wake_delay - 1)) state_d = ST_RUN;
        else                                      wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      o_sleep <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      o_sleep <= (state_d != ST_RUN);
    end
  end

endmodule
